tile_fetch_memory: RTL and testbench

- Parametrised successor to the accelerator's shared scratchpad RAM.
- Host port A: single-word write/read.
- Engine port B: a read-only tile-fetch engine. It walks a strided MxN sub-matrix (or a length-L vector) and streams zero-padded TILE-wide rows to the systolic array over a valid/ready handshake.
- Replaces whole-tile combinational fan-out with a sequential, back-pressurable row stream.

---
 rtl/tile_fetch_memory_if.sv | 45 ++++
 rtl/tile_fetch_memory.sv | 131 +++++++++++++
 tb/tb_tile_fetch_memory.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_fetch_memory_if.sv
// Host port, tile-fetch control and row-stream signals of tile_fetch_memory.
// The master side drives requests; the slave side is the memory/engine.
interface tile_fetch_memory_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned TILE   = 16
);
    localparam int unsigned IW = (TILE > 1) ? $clog2(TILE) : 1;

    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic                   rd_valid;

    logic                   fetch_start;
    logic                   fetch_mode;
    logic [ADDR_W-1:0]      fetch_base;
    logic [15:0]            fetch_rows;
    logic [15:0]            fetch_cols;
    logic [ADDR_W-1:0]      fetch_stride;
    logic                   fetch_busy;
    logic                   fetch_done;

    logic                   row_valid;
    logic                   row_ready;
    logic [TILE*DATA_W-1:0] row_data;
    logic [IW-1:0]          row_index;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output fetch_start, fetch_mode, fetch_base, fetch_rows, fetch_cols, fetch_stride,
        output row_ready,
        input  rd_data, rd_valid, fetch_busy, fetch_done, row_valid, row_data, row_index
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  fetch_start, fetch_mode, fetch_base, fetch_rows, fetch_cols, fetch_stride,
        input  row_ready,
        output rd_data, rd_valid, fetch_busy, fetch_done, row_valid, row_data, row_index
    );
endinterface

// File: rtl/tile_fetch_memory.sv
// Dual-port scratchpad: host word access on port A, and a tile-fetch engine on
// port B that streams zero-padded TILE-wide rows over a valid/ready handshake.
module tile_fetch_memory #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned TILE   = 16
) (
    input logic               clk,
    input logic               rst,
    tile_fetch_memory_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned IW    = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int unsigned CW    = $clog2(TILE) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic              mode_q;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] stride_q;
    logic [CW-1:0]     rows_q;
    logic [CW-1:0]     cols_q;
    logic [CW-1:0]     c_cnt;
    logic [DATA_W-1:0] b_data;
    logic [IW-1:0]     b_lane;
    logic              b_pend;

    logic              row_ok_c;
    logic [CW-1:0]     n_c;
    logic              last_c;

    // Port A write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end

    // Port A read; a simultaneous write wins and the read is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en & ~bus.wr_en;
            if (bus.rd_en && !bus.wr_en) bus.rd_data <= mem[bus.rd_addr];
        end
    end

    // Word count of the current row and whether it is the final row of the tile.
    always_comb begin
        row_ok_c = mode_q | (CW'(bus.row_index) < rows_q);
        n_c      = row_ok_c ? cols_q : '0;
        last_c   = mode_q | (bus.row_index == IW'(TILE - 1));
    end

    // Engine FSM: port-B reads land in b_data, then move into their lane a cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mode_q         <= 1'b0;
            row_addr       <= '0;
            stride_q       <= '0;
            rows_q         <= '0;
            cols_q         <= '0;
            c_cnt          <= '0;
            b_data         <= '0;
            b_lane         <= '0;
            b_pend         <= 1'b0;
            bus.fetch_busy <= 1'b0;
            bus.fetch_done <= 1'b0;
            bus.row_valid  <= 1'b0;
            bus.row_data   <= '0;
            bus.row_index  <= '0;
        end else begin
            b_pend         <= 1'b0;
            bus.fetch_done <= 1'b0;
            if (b_pend) bus.row_data[b_lane*DATA_W +: DATA_W] <= b_data;

            case (state)
                IDLE: begin
                    if (bus.fetch_start) begin
                        mode_q         <= bus.fetch_mode;
                        row_addr       <= bus.fetch_base;
                        stride_q       <= bus.fetch_stride;
                        rows_q         <= (bus.fetch_rows > 16'(TILE)) ? CW'(TILE) : CW'(bus.fetch_rows);
                        cols_q         <= (bus.fetch_cols > 16'(TILE)) ? CW'(TILE) : CW'(bus.fetch_cols);
                        c_cnt          <= '0;
                        bus.row_data   <= '0;
                        bus.row_index  <= '0;
                        bus.fetch_busy <= 1'b1;
                        state          <= FETCH;
                    end
                end
                FETCH: begin
                    if (c_cnt < n_c) begin
                        b_data <= mem[row_addr + ADDR_W'(c_cnt)];
                        b_lane <= IW'(c_cnt);
                        b_pend <= 1'b1;
                        c_cnt  <= c_cnt + 1'b1;
                    end else begin
                        bus.row_valid <= 1'b1;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.row_ready) begin
                        bus.row_valid <= 1'b0;
                        if (last_c) begin
                            bus.fetch_done <= 1'b1;
                            bus.fetch_busy <= 1'b0;
                            state          <= DONE;
                        end else begin
                            bus.row_index <= bus.row_index + 1'b1;
                            row_addr      <= row_addr + stride_q;
                            c_cnt         <= '0;
                            bus.row_data  <= '0;
                            state         <= FETCH;
                        end
                    end
                end
                DONE: begin
                    bus.row_index <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_fetch_memory.sv
// Randomised self-checking bench for tile_fetch_memory against a memory-array
// model and row expectations derived from base/stride/clamp rules.
module tb_tile_fetch_memory;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned TILE   = 16;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned IW     = $clog2(TILE);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_fetch_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TILE(TILE)) bus ();
    tile_fetch_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TILE(TILE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [DATA_W-1:0] model [DEPTH];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [TILE*DATA_W-1:0] exp_row(input bit mode, input int base,
            input int rows_eff, input int cols_eff, input int stride, input int r);
        logic [TILE*DATA_W-1:0] v;
        int n;
        v = '0;
        n = (mode || r < rows_eff) ? cols_eff : 0;
        for (int c = 0; c < n; c++)
            v[c*DATA_W +: DATA_W] = model[(base + r*stride + c) % DEPTH];
        return v;
    endfunction

    task automatic idle_inputs();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 0; bus.rd_addr = '0;
        bus.fetch_start = 0; bus.fetch_mode = 0; bus.fetch_base = '0;
        bus.fetch_rows = '0; bus.fetch_cols = '0; bus.fetch_stride = '0;
        bus.row_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.rd_data, bus.rd_valid, bus.fetch_busy, bus.fetch_done} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: rd_data=%h rd_valid=%b busy=%b done=%b want all 0",
                     bus.rd_data, bus.rd_valid, bus.fetch_busy, bus.fetch_done);
        end
        n_cmp++;
        if ({bus.row_valid, bus.row_data, bus.row_index} !== '0) begin
            n_err++;
            $display("FAIL reset_row: row_valid=%b row_index=%0d row_data=%h want 0",
                     bus.row_valid, bus.row_index, bus.row_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill_mem();
        for (int a = 0; a < int'(DEPTH); a++) begin
            bus.wr_en = 1; bus.wr_addr = ADDR_W'(a); bus.wr_data = DATA_W'(a);
            model[a] = DATA_W'(a);
            @(negedge clk);
        end
        bus.wr_en = 0;
        @(negedge clk);
    endtask

    task automatic test_host();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, held;
        bus.wr_en = 1; bus.wr_addr = 11'd5; bus.wr_data = 16'h1234; model[5] = 16'h1234;
        @(negedge clk);
        bus.wr_en = 0; bus.rd_en = 1; bus.rd_addr = 11'd5;
        @(negedge clk);
        bus.rd_en = 0;
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h1234) begin
            n_err++;
            $display("FAIL host_read5: rd_valid=%b rd_data=%h want 1/1234", bus.rd_valid, bus.rd_data);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h1234) begin
            n_err++;
            $display("FAIL host_hold: rd_valid=%b rd_data=%h want 0/1234", bus.rd_valid, bus.rd_data);
        end
        bus.wr_en = 1; bus.wr_addr = 11'd6; bus.wr_data = 16'hbeef; model[6] = 16'hbeef;
        bus.rd_en = 1; bus.rd_addr = 11'd6;
        @(negedge clk);
        bus.wr_en = 0; bus.rd_en = 0;
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h1234) begin
            n_err++;
            $display("FAIL host_rw_collide: rd_valid=%b rd_data=%h want 0/1234", bus.rd_valid, bus.rd_data);
        end
        held = 16'h1234;
        for (int i = 0; i < 40; i++) begin
            a = ADDR_W'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                d = DATA_W'($urandom);
                bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; model[a] = d;
                @(negedge clk);
                bus.wr_en = 0;
            end else begin
                bus.rd_en = 1; bus.rd_addr = a; held = model[a];
                @(negedge clk);
                bus.rd_en = 0;
                n_cmp++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== held) begin
                    n_err++;
                    $display("FAIL host_rand addr %0d: rd_valid=%b rd_data=%h want 1/%h",
                             a, bus.rd_valid, bus.rd_data, held);
                end
            end
        end
        @(negedge clk);
    endtask

    // Runs one complete tile fetch and checks every row, its timing and completion.
    task automatic do_fetch(input bit mode, input int base, input int rows, input int cols,
            input int stride, input int stall_row, input int stall_len, input bit rnd_ready,
            input string tag);
        int rows_eff, cols_eff, nrows, n, cyc, delay;
        logic [TILE*DATA_W-1:0] exp, snap_d;
        logic [IW-1:0] snap_i;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        bit bad;
        rows_eff = (rows > int'(TILE)) ? int'(TILE) : rows;
        cols_eff = (cols > int'(TILE)) ? int'(TILE) : cols;
        nrows    = mode ? 1 : int'(TILE);
        bus.fetch_start = 1; bus.fetch_mode = mode; bus.fetch_base = ADDR_W'(base);
        bus.fetch_rows = 16'(rows); bus.fetch_cols = 16'(cols); bus.fetch_stride = ADDR_W'(stride);
        @(negedge clk);
        bus.fetch_start = 0;
        n_cmp++;
        if (bus.fetch_busy !== 1'b1 || bus.row_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s entry: busy=%b row_valid=%b want 1/0", tag, bus.fetch_busy, bus.row_valid);
        end
        for (int r = 0; r < nrows; r++) begin
            n = (mode || r < rows_eff) ? cols_eff : 0;
            cyc = 0;
            while (bus.row_valid !== 1'b1 && cyc < 64) begin
                @(negedge clk);
                cyc++;
            end
            n_cmp++;
            if (cyc != n + 1) begin
                n_err++;
                $display("FAIL %s latency row %0d: got %0d cycles want %0d", tag, r, cyc, n + 1);
            end
            exp = exp_row(mode, base, rows_eff, cols_eff, stride, r);
            n_cmp++;
            if (bus.row_data !== exp || bus.row_index !== IW'(r)) begin
                n_err++;
                $display("FAIL %s row %0d: index=%0d data=%h want index=%0d data=%h",
                         tag, r, bus.row_index, bus.row_data, r, exp);
            end
            delay = (r == stall_row) ? stall_len : (rnd_ready ? int'($urandom_range(0, 2)) : 0);
            snap_d = bus.row_data; snap_i = bus.row_index; bad = 0;
            for (int d = 0; d < delay; d++) begin
                if (r == stall_row) begin
                    wa = ADDR_W'((base + r*stride + int'($urandom_range(0, TILE - 1))) % DEPTH);
                    wd = DATA_W'($urandom);
                    bus.wr_en = 1; bus.wr_addr = wa; bus.wr_data = wd; model[wa] = wd;
                    if (d == 3) begin
                        bus.fetch_start = 1; bus.fetch_mode = ~mode;
                        bus.fetch_base = ADDR_W'($urandom); bus.fetch_stride = ADDR_W'($urandom);
                        bus.fetch_rows = 16'd1; bus.fetch_cols = 16'd2;
                    end
                end
                @(negedge clk);
                bus.wr_en = 0; bus.fetch_start = 0;
                if (bus.row_valid !== 1'b1 || bus.row_data !== snap_d ||
                    bus.row_index !== snap_i || bus.fetch_busy !== 1'b1) bad = 1;
            end
            if (delay > 0) begin
                n_cmp++;
                if (bad) begin
                    n_err++;
                    $display("FAIL %s stall row %0d: now index=%0d valid=%b data=%h want index=%0d valid=1 data=%h",
                             tag, r, bus.row_index, bus.row_valid, bus.row_data, snap_i, snap_d);
                end
            end
            bus.row_ready = 1;
            @(negedge clk);
            bus.row_ready = 0;
            if (r < nrows - 1) begin
                n_cmp++;
                if (bus.row_valid !== 1'b0 || bus.row_index !== IW'(r + 1) || bus.fetch_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s advance row %0d: valid=%b index=%0d busy=%b want 0/%0d/1",
                             tag, r, bus.row_valid, bus.row_index, bus.fetch_busy, r + 1);
                end
            end else begin
                n_cmp++;
                if (bus.fetch_done !== 1'b1 || bus.fetch_busy !== 1'b0 || bus.row_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s done: done=%b busy=%b valid=%b want 1/0/0",
                             tag, bus.fetch_done, bus.fetch_busy, bus.row_valid);
                end
                @(negedge clk);
                n_cmp++;
                if (bus.fetch_done !== 1'b0 || bus.row_index !== '0 || bus.fetch_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s idle: done=%b index=%0d busy=%b want 0/0/0",
                             tag, bus.fetch_done, bus.row_index, bus.fetch_busy);
                end
            end
        end
    endtask

    task automatic test_matrix_3x4();
        do_fetch(1'b0, 100, 3, 4, 20, -1, 0, 1'b0, "mat3x4");
    endtask

    task automatic test_vector_wrap();
        do_fetch(1'b1, 2040, 9, 20, 5, -1, 0, 1'b0, "vec_wrap");
    endtask

    task automatic test_backpressure();
        do_fetch(1'b0, 300, 5, 8, 37, 1, 10, 1'b0, "backpressure");
    endtask

    task automatic test_zero_rows();
        do_fetch(1'b0, 700, 0, 7, 3, -1, 0, 1'b0, "zero_rows");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            do_fetch($urandom_range(0, 2) == 0, int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                     int'($urandom_range(0, DEPTH - 1)), -1, 0, 1'b1, "random");
    endtask

    task automatic test_reset_mid();
        int guard;
        bus.row_ready = 1;
        bus.fetch_start = 1; bus.fetch_mode = 0; bus.fetch_base = 11'd50;
        bus.fetch_rows = 16'd10; bus.fetch_cols = 16'd6; bus.fetch_stride = 11'd9;
        @(negedge clk);
        bus.fetch_start = 0;
        guard = 0;
        while (bus.row_index !== IW'(4) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        bus.row_ready = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (guard >= 500 || {bus.rd_valid, bus.fetch_busy, bus.fetch_done, bus.row_valid,
                             bus.row_data, bus.row_index} !== '0 || bus.rd_data !== '0) begin
            n_err++;
            $display("FAIL reset_mid: guard=%0d busy=%b valid=%b index=%0d data=%h want all 0",
                     guard, bus.fetch_busy, bus.row_valid, bus.row_index, bus.row_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.fetch_busy !== 1'b0 || bus.row_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_idle: busy=%b valid=%b want 0/0", bus.fetch_busy, bus.row_valid);
        end
        do_fetch(1'b0, 1000, 6, 16, 100, -1, 0, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        fill_mem();
        test_host();
        test_matrix_3x4();
        test_vector_wrap();
        test_backpressure();
        test_zero_rows();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
